// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed seven-segment driver with frame-atomic digit
// snapshot, leading-zero blanking, per-digit decimal point and enable.
module bcd_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank_lz,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0]     r_cnt;
  logic [1:0]      r_sel;
  logic [3:0][3:0] r_dig;
  logic [3:0]      r_dpm;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic       w_wrap;
  logic       w_frame;
  logic [3:0] w_digit;
  logic [6:0] w_dec;
  logic       w_blank;
  logic       w_z3;
  logic       w_z2;
  logic       w_z1;

  assign w_wrap  = (r_cnt == LAST);
  assign w_frame = w_wrap && (r_sel == 2'd3);
  assign w_digit = r_dig[r_sel];
  assign w_z3    = (r_dig[3] == 4'd0);
  assign w_z2    = (r_dig[2] == 4'd0);
  assign w_z1    = (r_dig[1] == 4'd0);

  always_comb begin
    w_dec = 7'b1111110;
    case (w_digit)
      4'd0:    w_dec = 7'b0000001;
      4'd1:    w_dec = 7'b1001111;
      4'd2:    w_dec = 7'b0010010;
      4'd3:    w_dec = 7'b0000110;
      4'd4:    w_dec = 7'b1001100;
      4'd5:    w_dec = 7'b0100100;
      4'd6:    w_dec = 7'b0100000;
      4'd7:    w_dec = 7'b0001111;
      4'd8:    w_dec = 7'b0000000;
      4'd9:    w_dec = 7'b0000100;
      default: w_dec = 7'b1111110;
    endcase
  end

  // Blanking looks only at the snapshot, so a frame stays self-consistent
  always_comb begin
    w_blank = 1'b0;
    unique case (r_sel)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = blank_lz && w_z3 && w_z2 && w_z1;
      2'd2: w_blank = blank_lz && w_z3 && w_z2;
      2'd3: w_blank = blank_lz && w_z3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_dig <= '0;
      r_dpm <= '0;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_cnt <= w_wrap ? 16'd0 : r_cnt + 16'd1;
      if (w_wrap) r_sel <= r_sel + 2'd1;
      if (w_frame) begin
        r_dig <= {d3, d2, d1, d0};
        r_dpm <= dp_in;
      end
      r_an  <= en ? ~(4'b0001 << r_sel) : 4'b1111;
      r_seg <= w_blank ? 7'b1111111 : w_dec;
      r_dp  <= ~r_dpm[r_sel];
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: stimulus pushes hand-computed
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_bcd_scan_display;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       blank_lz;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  exp_t q[$];
  int   total;
  int   bad;
  int   pushed;
  int   step_no;

  bcd_scan_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .blank_lz (blank_lz),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .dp_in    (dp_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        bad++;
        $display("FAIL cycle%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 total, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic ex(input logic [3:0] a, input logic [6:0] s,
                    input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.an  = a;
      e.seg = s;
      e.dp  = p;
      q.push_back(e);
      pushed++;
      @(posedge clk);
      #1;
      step_no++;
    end
  endtask

  task automatic dig(input int k, input logic [6:0] s,
                     input logic p, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << k);
    ex(a, s, p, n);
  endtask

  task automatic frm(input logic [6:0] s0, input logic [6:0] s1,
                     input logic [6:0] s2, input logic [6:0] s3,
                     input logic [3:0] dpm);
    dig(0, s0, ~dpm[0], 4);
    dig(1, s1, ~dpm[1], 4);
    dig(2, s2, ~dpm[2], 4);
    dig(3, s3, ~dpm[3], 4);
  endtask

  initial begin
    total = 0; bad = 0; pushed = 0; step_no = 0;
    rst = 1'b1; en = 1'b1; blank_lz = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    dp_in = 4'b0000;

    // reset held three edges
    ex(4'b1111, 7'b1111111, 1'b1, 3);
    rst = 1'b0;
    // frame 1: zero snapshot, only digit0 lit
    frm(7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0000);
    // frame 2: 4321; d0 changes now, visible from frame 3
    d0 = 4'd5;
    frm(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b0000);
    // frame 3: d0=5, change to 6 mid-digit
    dig(0, 7'b0100100, 1'b1, 2);
    d0 = 4'd6;
    dig(0, 7'b0100100, 1'b1, 2);
    dig(1, 7'b0010010, 1'b1, 4);
    dig(2, 7'b0000110, 1'b1, 4);
    dig(3, 7'b1001100, 1'b1, 4);
    // frame 4: d0=6; load 0,0,7,0 for next frame
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd7; d0 = 4'd0;
    frm(7'b0100000, 7'b0010010, 7'b0000110, 7'b1001100, 4'b0000);
    // frame 5: leading-zero blanking on
    frm(7'b0000001, 7'b0001111, 7'b1111111, 7'b1111111, 4'b0000);
    // frame 6: blanking off; queue non-BCD digit and dp for frame 7
    blank_lz = 1'b0;
    d3 = 4'd0; d2 = 4'd12; d1 = 4'd0; d0 = 4'd9;
    dp_in = 4'b0100;
    frm(7'b0000001, 7'b0001111, 7'b0000001, 7'b0000001, 4'b0000);
    // frame 7: non-BCD counts as non-zero for blanking
    blank_lz = 1'b1;
    frm(7'b0000100, 7'b0000001, 7'b1111110, 7'b1111111, 4'b0100);
    // frame 8: enable drop for 5 cycles, then reset during digit2
    dig(0, 7'b0000100, 1'b1, 2);
    en = 1'b0;
    ex(4'b1111, 7'b0000100, 1'b1, 2);
    ex(4'b1111, 7'b0000001, 1'b1, 3);
    en = 1'b1;
    dig(1, 7'b0000001, 1'b1, 1);
    dig(2, 7'b1111110, 1'b0, 2);
    rst = 1'b1;
    ex(4'b1111, 7'b1111111, 1'b1, 1);
    rst = 1'b0;
    // restart from digit0 with zero snapshot, then reload
    frm(7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0000);
    frm(7'b0000100, 7'b0000001, 7'b1111110, 7'b1111111, 4'b0100);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0 || total != pushed) begin
      bad++;
      $display("FAIL drain: got %0d checked want %0d", total, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
